// File: rtl/fir_pkg.sv
// Shared constants and types for the 27-tap FIR coefficient path.
// HALF is derived from NTAP and is the number of taps loaded in symmetric mode.
package fir_pkg;
  localparam int NTAP  = 27;
  localparam int CW    = 9;
  localparam int HALF  = (NTAP + 1) / 2;
  localparam int CNT_W = 5;

  typedef logic signed [CW-1:0] coef_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMMIT
  } ld_state_e;
endpackage

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient register banks.
// A commit copies the whole shadow into active in one edge, optionally mirrored.
module fir_coef_bank
  import fir_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [CNT_W-1:0]     widx,
  input  coef_t                wdata,
  input  logic                 commit,
  input  logic                 sym,
  output logic [NTAP*CW-1:0]   h_bus
);

  coef_t shadow [NTAP];
  coef_t active [NTAP];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NTAP; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NTAP; k++) begin
        if (we && widx == CNT_W'(k)) shadow[k] <= wdata;
        // Upper taps take the mirror of the lower half; centre tap maps to itself.
        if (commit) active[k] <= (sym && k >= HALF) ? shadow[NTAP-1-k] : shadow[k];
      end
    end
  end

  for (genvar k = 0; k < NTAP; k++) begin : g_tap
    assign h_bus[k*CW +: CW] = active[k];
  end

endmodule

// File: rtl/fir_coef_loader.sv
// Serial coefficient loader: valid/ready stream into a shadow bank, atomic commit to
// the active bank that drives the FIR taps.
module fir_coef_loader
  import fir_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 load_start,
  input  logic                 sym,
  input  coef_t                coef_in,
  input  logic                 coef_valid,
  output logic                 coef_ready,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     load_cnt,
  output logic [NTAP*CW-1:0]   h_bus
);

  ld_state_e        state;
  logic             sym_q;
  logic [CNT_W-1:0] n_last;
  logic             we;
  logic             commit;

  assign n_last     = sym_q ? CNT_W'(HALF - 1) : CNT_W'(NTAP - 1);
  assign coef_ready = (state == ST_LOAD);
  assign busy       = (state != ST_IDLE);
  // A restart or clear in the same cycle swallows the beat.
  assign we         = coef_ready & coef_valid & ~load_start & ~clr;
  assign commit     = (state == ST_COMMIT) & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sym_q    <= 1'b0;
      load_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clr) begin
        state    <= ST_IDLE;
        load_cnt <= '0;
      end else begin
        unique case (state)
          ST_IDLE: if (load_start) begin
            sym_q    <= sym;
            load_cnt <= '0;
            state    <= ST_LOAD;
          end
          ST_LOAD: begin
            if (load_start) begin
              sym_q    <= sym;
              load_cnt <= '0;
            end else if (coef_valid) begin
              load_cnt <= load_cnt + 1'b1;
              if (load_cnt == n_last) state <= ST_COMMIT;
            end
          end
          ST_COMMIT: begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  fir_coef_bank u_bank (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (we),
    .widx   (load_cnt),
    .wdata  (coef_in),
    .commit (commit),
    .sym    (sym_q),
    .h_bus  (h_bus)
  );

endmodule

// File: tb/tb_fir_coef_loader.sv
// Randomized bench for fir_coef_loader against a tap-array model of the active set.
module tb_fir_coef_loader;
  import fir_pkg::*;

  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0, load_start = 1'b0, sym = 1'b0, coef_valid = 1'b0;
  coef_t coef_in = '0;
  logic coef_ready, busy, done;
  logic [CNT_W-1:0] load_cnt;
  logic [NTAP*CW-1:0] h_bus;

  int errors = 0, checks = 0;
  logic [CW-1:0] stim    [NTAP];
  logic [CW-1:0] exp_act [NTAP];

  always #5 clk = ~clk;

  fir_coef_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .load_start (load_start),
    .sym        (sym),
    .coef_in    (coef_in),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .busy       (busy),
    .done       (done),
    .load_cnt   (load_cnt),
    .h_bus      (h_bus)
  );

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [NTAP*CW-1:0] exp_bus();
    logic [NTAP*CW-1:0] b;
    for (int k = 0; k < NTAP; k++) b[k*CW +: CW] = exp_act[k];
    return b;
  endfunction

  // Model: a completed load makes the streamed list the active set (mirrored if sym).
  task automatic model_commit(input bit s);
    if (!s) begin
      for (int k = 0; k < NTAP; k++) exp_act[k] = stim[k];
    end else begin
      for (int k = 0; k < HALF; k++) begin
        exp_act[k]        = stim[k];
        exp_act[NTAP-1-k] = stim[k];
      end
    end
  endtask

  task automatic run_load(input bit s, input bit bursty, input bit junk, input string tag);
    int n = s ? HALF : NTAP;
    int acc = 0;
    int cyc = 0;
    bit v;
    logic [NTAP*CW-1:0] old_bus = exp_bus();
    load_start = 1'b1; sym = s; coef_valid = junk; coef_in = coef_t'(-7);
    @(negedge clk); cyc = 1;
    load_start = 1'b0;
    chk({tag, ":ready0"}, 256'(coef_ready), 256'(1));
    chk({tag, ":cnt0"}, 256'(load_cnt), 256'(0));
    while (acc < n && cyc < 400) begin
      v = bursty ? 1'($urandom_range(0, 1)) : 1'b1;
      coef_valid = v; coef_in = stim[acc];
      @(negedge clk); cyc++;
      if (v) acc++;
      if (acc < n) begin
        chk({tag, ":hold"}, 256'({done, h_bus}), 256'({1'b0, old_bus}));
        chk({tag, ":cnt"}, 256'(load_cnt), 256'(acc));
      end
    end
    coef_valid = 1'b0;
    if (cyc >= 400) begin
      chk({tag, ":timeout"}, 256'(0), 256'(1));
      return;
    end
    chk({tag, ":cnt_commit"}, 256'(load_cnt), 256'(n));
    chk({tag, ":commit_st"}, 256'({busy, coef_ready}), 256'(2'b10));
    chk({tag, ":pre_bus"}, 256'({done, h_bus}), 256'({1'b0, old_bus}));
    model_commit(s);
    @(negedge clk); cyc++;
    chk({tag, ":done"}, 256'({done, busy}), 256'(2'b10));
    chk({tag, ":bus"}, 256'(h_bus), 256'(exp_bus()));
    if (!bursty) chk({tag, ":latency"}, 256'(cyc), 256'(n + 2));
    @(negedge clk);
    chk({tag, ":done_fall"}, 256'({done, h_bus}), 256'({1'b0, exp_bus()}));
  endtask

  task automatic partial(input bit s, input int nb, input string tag);
    load_start = 1'b1; sym = s; coef_valid = 1'b0;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < nb; i++) begin
      coef_valid = 1'b1; coef_in = stim[i];
      @(negedge clk);
    end
    coef_valid = 1'b0;
    chk({tag, ":pcnt"}, 256'(load_cnt), 256'(nb));
    chk({tag, ":phold"}, 256'({done, h_bus}), 256'({1'b0, exp_bus()}));
  endtask

  task automatic rand_stim();
    for (int k = 0; k < NTAP; k++) stim[k] = CW'($urandom_range(0, (1 << CW) - 1));
  endtask

  initial begin
    for (int k = 0; k < NTAP; k++) exp_act[k] = '0;
    repeat (2) @(negedge clk);
    chk("reset_outs", 256'({coef_ready, busy, done, load_cnt}), 256'(0));
    chk("reset_bus", 256'(h_bus), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < NTAP; k++) stim[k] = CW'(k - 13);
    run_load(1'b0, 1'b0, 1'b0, "ramp");
    chk("ramp_tap0", 256'(h_bus[0 +: CW]), 256'(9'h1F3));
    chk("ramp_tap26", 256'(h_bus[26*CW +: CW]), 256'(13));

    for (int k = 0; k < HALF; k++) stim[k] = CW'(k + 1);
    run_load(1'b1, 1'b0, 1'b0, "sym");
    chk("sym_tap0_26", 256'({h_bus[0 +: CW], h_bus[26*CW +: CW]}), 256'({9'd1, 9'd1}));
    chk("sym_tap12_14", 256'({h_bus[12*CW +: CW], h_bus[14*CW +: CW]}), 256'({9'd13, 9'd13}));
    chk("sym_tap13", 256'(h_bus[13*CW +: CW]), 256'(14));

    rand_stim();
    run_load(1'b0, 1'b1, 1'b0, "bp");

    rand_stim();
    partial(1'b0, 10, "restart_pre");
    for (int k = 0; k < NTAP; k++) stim[k] = CW'(5);
    run_load(1'b0, 1'b0, 1'b1, "restart");

    for (int k = 0; k < NTAP; k++) stim[k] = CW'(1);
    run_load(1'b0, 1'b0, 1'b0, "ones");
    for (int k = 0; k < NTAP; k++) stim[k] = CW'(2);
    partial(1'b0, 5, "clr_pre");
    clr = 1'b1; coef_valid = 1'b1; coef_in = stim[5];
    @(negedge clk);
    clr = 1'b0; coef_valid = 1'b0;
    chk("clr_state", 256'({coef_ready, busy, done, load_cnt}), 256'(0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("clr_hold", 256'({done, busy, h_bus}), 256'({2'b00, exp_bus()}));
    end

    for (int i = 0; i < 6; i++) begin
      rand_stim();
      run_load(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd");
    end

    rand_stim();
    partial(1'b1, 7, "rst_pre");
    #2 rst_n = 1'b0;
    #1;
    chk("rst_outs", 256'({coef_ready, busy, done, load_cnt}), 256'(0));
    chk("rst_bus", 256'(h_bus), 256'(0));
    for (int k = 0; k < NTAP; k++) exp_act[k] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_idle", 256'({coef_ready, busy, done}), 256'(0));
    rand_stim();
    run_load(1'b0, 1'b0, 1'b0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
